// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter.
// State, owner and bank-select encodings.
package data_memory_arbiter_pkg;

    typedef enum logic [0:0] {
        CPU_OWN   = 1'b0,
        DMA_BURST = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic BANK_EVEN = 1'b0;
    localparam logic BANK_ODD  = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_mapper.sv
// Splits one byte/halfword access onto the even/odd byte banks.
// Purely combinational; the low byte always lands in bank addr[0].
module bank_mapper
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              half,
    input  logic              we,
    input  logic [15:0]       wdata,
    output logic [ADDR_W-2:0] evenAddr,
    output logic [ADDR_W-2:0] oddAddr,
    output logic              evenWe,
    output logic              oddWe,
    output logic [7:0]        evenWdata,
    output logic [7:0]        oddWdata
);

    logic              lowBank;
    logic [ADDR_W-2:0] wordAddr;

    assign lowBank  = addr[0];
    assign wordAddr = addr[ADDR_W-1:1];

    // Odd start: the high byte sits in the next even word (wraps at top).
    assign oddAddr  = wordAddr;
    assign evenAddr = (lowBank == BANK_ODD) ? wordAddr + 1'b1 : wordAddr;

    assign evenWe = en && we && (half || lowBank == BANK_EVEN);
    assign oddWe  = en && we && (half || lowBank == BANK_ODD);

    assign evenWdata = (lowBank == BANK_ODD) ? wdata[15:8] : wdata[7:0];
    assign oddWdata  = (lowBank == BANK_ODD) ? wdata[7:0]  : wdata[15:8];

endmodule

// File: rtl/data_memory_arbiter.sv
// CPU / DMA arbiter for the split even/odd byte-bank data memory.
// Grants are decided from requests and counters only, never bank data.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int BURST_MAX    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_half,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_gnt,
    output logic [7:0]        dma_rdata,
    output logic              dma_rvalid,
    output logic              even_we,
    output logic              odd_we,
    output logic [ADDR_W-2:0] even_addr,
    output logic [ADDR_W-2:0] odd_addr,
    output logic [7:0]        even_wdata,
    output logic [7:0]        odd_wdata,
    input  logic [7:0]        even_rdata,
    input  logic [7:0]        odd_rdata
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    arb_state_t        state;
    logic [WAIT_W-1:0] waitCnt;
    logic [BEAT_W-1:0] beatCnt;

    logic              cpuGnt;
    logic              dmaGnt;

    logic [ADDR_W-1:0] reqAddr;
    logic              reqHalf;
    logic              reqWe;
    logic [15:0]       reqWdata;

    logic              rdValid;
    owner_t            rdOwner;
    logic              rdA0;
    logic              rdHalf;
    logic [7:0]        byteLo;
    logic [7:0]        byteHi;
    logic              cpuRv;
    logic              dmaRv;

    always_comb begin
        cpuGnt = 1'b0;
        dmaGnt = 1'b0;
        if (!reset) begin
            case (state)
                CPU_OWN: dmaGnt = dma_req &&
                    (!cpu_req || waitCnt == WAIT_W'(STARVE_LIMIT));
                DMA_BURST: dmaGnt = dma_req &&
                    (beatCnt < BEAT_W'(BURST_MAX));
                default: dmaGnt = 1'b0;
            endcase
            cpuGnt = cpu_req && !dmaGnt;
        end
    end

    assign dma_gnt   = dmaGnt;
    assign cpu_stall = cpu_req && !cpuGnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CPU_OWN;
            waitCnt <= '0;
            beatCnt <= '0;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (dmaGnt && cpu_req) begin
                        state   <= DMA_BURST;
                        beatCnt <= BEAT_W'(1);
                        waitCnt <= '0;
                    end else if (dma_req && cpu_req) begin
                        waitCnt <= waitCnt + 1'b1;
                    end else begin
                        waitCnt <= '0;
                    end
                end
                DMA_BURST: begin
                    if (dmaGnt) begin
                        beatCnt <= beatCnt + 1'b1;
                    end else begin
                        state   <= CPU_OWN;
                        beatCnt <= '0;
                    end
                end
                default: state <= CPU_OWN;
            endcase
        end
    end

    // DMA beats are always single bytes.
    always_comb begin
        reqAddr  = cpu_addr;
        reqHalf  = cpu_half;
        reqWe    = cpu_we;
        reqWdata = cpu_wdata;
        if (dmaGnt) begin
            reqAddr  = dma_addr;
            reqHalf  = 1'b0;
            reqWe    = dma_we;
            reqWdata = {8'h00, dma_wdata};
        end
    end

    bank_mapper #(
        .ADDR_W (ADDR_W)
    ) uMapper (
        .en        (cpuGnt || dmaGnt),
        .addr      (reqAddr),
        .half      (reqHalf),
        .we        (reqWe),
        .wdata     (reqWdata),
        .evenAddr  (even_addr),
        .oddAddr   (odd_addr),
        .evenWe    (even_we),
        .oddWe     (odd_we),
        .evenWdata (even_wdata),
        .oddWdata  (odd_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rdValid <= 1'b0;
            rdOwner <= OWN_CPU;
            rdA0    <= 1'b0;
            rdHalf  <= 1'b0;
        end else begin
            rdValid <= (cpuGnt && !cpu_we) || (dmaGnt && !dma_we);
            rdOwner <= dmaGnt ? OWN_DMA : OWN_CPU;
            rdA0    <= reqAddr[0];
            rdHalf  <= reqHalf;
        end
    end

    assign byteLo = rdA0 ? odd_rdata : even_rdata;
    assign byteHi = rdA0 ? even_rdata : odd_rdata;

    assign cpuRv = rdValid && rdOwner == OWN_CPU && !reset;
    assign dmaRv = rdValid && rdOwner == OWN_DMA && !reset;

    assign cpu_rvalid = cpuRv;
    assign dma_rvalid = dmaRv;
    assign cpu_rdata  = !cpuRv ? 16'h0000 :
                        rdHalf ? {byteHi, byteLo} : {8'h00, byteLo};
    assign dma_rdata  = dmaRv ? byteLo : 8'h00;

endmodule
